// File: rtl/rob_pkg.sv
// Shared widths, the completion packet type and a popcount helper for the
// ROB completion-port arbiter.
package rob_pkg;

  localparam int ROB_SIZE      = 64;
  localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE);
  localparam int NUM_TAGS      = 64;
  localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
  localparam int REG_SIZE      = 32;

  typedef struct packed {
    logic [ROB_SIZE_LOG2-1:0] rob_index;
    logic [NUM_TAGS_LOG2-1:0] tag;
    logic [REG_SIZE-1:0]      data;
  } complete_pkt_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_multi_pick.sv
// Combinational round-robin picker: grants up to NUM_PORTS requesters starting
// at start_i, packing them onto ports 0 upward in scan order.
module rr_multi_pick #(
  parameter int NUM_FU    = 6,
  parameter int NUM_PORTS = 3,
  parameter int PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0]    req_i,
  input  logic [PTR_W-1:0]     start_i,
  input  logic                 en_i,
  output logic [NUM_FU-1:0]    grant_o,
  output logic [PTR_W-1:0]     port_idx_o [NUM_PORTS],
  output logic [NUM_PORTS-1:0] port_vld_o,
  output logic [PTR_W-1:0]     last_idx_o,
  output logic                 any_o
);

  localparam int CNT_W  = $clog2(NUM_PORTS + 1);
  localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [CNT_W-1:0] cnt_s;
  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;

  // Modular scan from start_i; the wrap is an explicit subtract so NUM_FU
  // need not be a power of two.
  always_comb begin
    grant_o    = '0;
    port_vld_o = '0;
    last_idx_o = start_i;
    cnt_s      = '0;
    sum_s      = '0;
    idx_s      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      port_idx_o[k] = '0;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      sum_s = {1'b0, start_i} + (PTR_W+1)'(i);
      if (sum_s >= (PTR_W+1)'(NUM_FU)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_FU);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (en_i && req_i[idx_s] && (cnt_s < CNT_W'(NUM_PORTS))) begin
        grant_o[idx_s]                  = 1'b1;
        port_idx_o[cnt_s[PIDX_W-1:0]]   = idx_s;
        port_vld_o[cnt_s[PIDX_W-1:0]]   = 1'b1;
        last_idx_o                      = idx_s;
        cnt_s                           = cnt_s + CNT_W'(1);
      end else begin
        cnt_s = cnt_s;
      end
    end
    any_o = |grant_o;
  end

endmodule

// File: rtl/rob_complete_arbiter.sv
// Shares the ROB completion write-back ports among NUM_FU functional units.
// Optional perf counters are built when COMPLETE_ARB_PERF_EN is defined.
module rob_complete_arbiter
  import rob_pkg::*;
#(
  parameter int NUM_FU    = 6,
  parameter int NUM_PORTS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fu_req          [0:NUM_FU-1],
  input  logic [ROB_SIZE_LOG2-1:0] fu_rob_index    [0:NUM_FU-1],
  input  logic [NUM_TAGS_LOG2-1:0] fu_tag          [0:NUM_FU-1],
  input  logic [REG_SIZE-1:0]      fu_data         [0:NUM_FU-1],
  output logic                     fu_grant        [0:NUM_FU-1],
  output logic                     complete        [0:NUM_PORTS-1],
  output logic [ROB_SIZE_LOG2-1:0] rob_index       [0:NUM_PORTS-1],
  output logic [NUM_TAGS_LOG2-1:0] tag_rd_complete [0:NUM_PORTS-1],
  output logic [REG_SIZE-1:0]      data_rd         [0:NUM_PORTS-1],
`ifdef COMPLETE_ARB_PERF_EN
  output logic [31:0]              perf_grants,
  output logic [31:0]              perf_conflicts,
`endif
  output logic                     arb_conflict
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]    req_vec_s;
  logic [NUM_FU-1:0]    grant_vec_s;
  complete_pkt_t        fu_pkt_s   [NUM_FU];
  logic [PTR_W-1:0]     port_idx_s [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_vld_s;
  logic [PTR_W-1:0]     last_idx_s;
  logic                 any_grant_s;
  logic                 pick_en_s;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  complete_pkt_t        port_q [NUM_PORTS];
  complete_pkt_t        port_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] complete_q, complete_d;
  logic                 conflict_q, conflict_d;

  // Grants are held off during reset as well as flush.
  assign pick_en_s = rst_n & ~flush;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      req_vec_s[i] = fu_req[i];
      fu_pkt_s[i]  = '{rob_index: fu_rob_index[i], tag: fu_tag[i], data: fu_data[i]};
      fu_grant[i]  = grant_vec_s[i];
    end
  end

  rr_multi_pick #(
    .NUM_FU    (NUM_FU),
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req_i      (req_vec_s),
    .start_i    (rr_ptr_q),
    .en_i       (pick_en_s),
    .grant_o    (grant_vec_s),
    .port_idx_o (port_idx_s),
    .port_vld_o (port_vld_s),
    .last_idx_o (last_idx_s),
    .any_o      (any_grant_s)
  );

  // Unused ports are zeroed so the ROB never sees stale fields.
  always_comb begin
    complete_d = port_vld_s;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (port_vld_s[k]) begin
        port_d[k] = fu_pkt_s[port_idx_s[k]];
      end else begin
        port_d[k] = '0;
      end
    end
    if (!any_grant_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if (last_idx_s == PTR_W'(NUM_FU - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = last_idx_s + PTR_W'(1);
    end
    conflict_d = (popcount(32'(req_vec_s)) > NUM_PORTS) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      complete_q <= '0;
      conflict_q <= 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        port_q[k] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      complete_q <= complete_d;
      conflict_q <= conflict_d;
      for (int k = 0; k < NUM_PORTS; k++) begin
        port_q[k] <= port_d[k];
      end
    end
  end

  always_comb begin
    arb_conflict = conflict_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      complete[k]        = complete_q[k];
      rob_index[k]       = port_q[k].rob_index;
      tag_rd_complete[k] = port_q[k].tag;
      data_rd[k]         = port_q[k].data;
    end
  end

`ifdef COMPLETE_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_conflicts_q;

  // Free-running wrap-around counters; flush does not clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants_q    <= 32'd0;
      perf_conflicts_q <= 32'd0;
    end else begin
      perf_grants_q    <= perf_grants_q + 32'(popcount(32'(grant_vec_s)));
      perf_conflicts_q <= perf_conflicts_q + {31'd0, conflict_d};
    end
  end

  assign perf_grants    = perf_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed, table-driven bench for rob_complete_arbiter.
module tb_rob_complete_arbiter;
  import rob_pkg::*;

  localparam int NF = 6;
  localparam int NP = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     fu_req          [0:NF-1];
  logic [ROB_SIZE_LOG2-1:0] fu_rob_index    [0:NF-1];
  logic [NUM_TAGS_LOG2-1:0] fu_tag          [0:NF-1];
  logic [REG_SIZE-1:0]      fu_data         [0:NF-1];
  logic                     fu_grant        [0:NF-1];
  logic                     complete        [0:NP-1];
  logic [ROB_SIZE_LOG2-1:0] rob_index       [0:NP-1];
  logic [NUM_TAGS_LOG2-1:0] tag_rd_complete [0:NP-1];
  logic [REG_SIZE-1:0]      data_rd         [0:NP-1];
  logic                     arb_conflict;
`ifdef COMPLETE_ARB_PERF_EN
  logic [31:0]              perf_grants;
  logic [31:0]              perf_conflicts;
`endif

  rob_complete_arbiter #(.NUM_FU(NF), .NUM_PORTS(NP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .fu_req          (fu_req),
    .fu_rob_index    (fu_rob_index),
    .fu_tag          (fu_tag),
    .fu_data         (fu_data),
    .fu_grant        (fu_grant),
    .complete        (complete),
    .rob_index       (rob_index),
    .tag_rd_complete (tag_rd_complete),
    .data_rd         (data_rd),
`ifdef COMPLETE_ARB_PERF_EN
    .perf_grants     (perf_grants),
    .perf_conflicts  (perf_conflicts),
`endif
    .arb_conflict    (arb_conflict)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] req;
    logic       flush;
    logic [5:0] grant;
    int         p0;
    int         p1;
    int         p2;
    logic       conflict;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {complete, rob_index, tag, data} for a port carrying FU fu (-1 = idle)
  function automatic logic [63:0] exp_port(input int fu);
    logic [63:0] v;
    if (fu < 0) begin
      v = 64'd0;
    end else begin
      v = {19'd0, 1'b1, 6'(fu + 8), 6'(fu + 40), 32'hA0 + 32'(fu)};
    end
    return v;
  endfunction

  function automatic logic [63:0] act_port(input int k);
    return {19'd0, complete[k], rob_index[k], tag_rd_complete[k], data_rd[k]};
  endfunction

  function automatic logic [63:0] grant_vec();
    logic [63:0] g;
    g = 64'd0;
    for (int i = 0; i < NF; i++) g[i] = fu_grant[i];
    return g;
  endfunction

  task automatic set_req(input logic [5:0] r);
    for (int i = 0; i < NF; i++) fu_req[i] = r[i];
  endtask

  task automatic check_idle(input string name);
    for (int k = 0; k < NP; k++) check($sformatf("%s_port%0d", name, k), act_port(k), 64'd0);
    check({name, "_conflict"}, {63'd0, arb_conflict}, 64'd0);
    check({name, "_grant"}, grant_vec(), 64'd0);
  endtask

  task automatic step(input string name, input logic [5:0] r, input logic f, input logic [5:0] eg,
                      input int p0, input int p1, input int p2, input logic ec);
    @(negedge clk);
    set_req(r);
    flush = f;
    #1;
    check({name, "_grant"}, grant_vec(), {58'd0, eg});
    @(posedge clk);
    #1;
    check({name, "_port0"}, act_port(0), exp_port(p0));
    check({name, "_port1"}, act_port(1), exp_port(p1));
    check({name, "_port2"}, act_port(2), exp_port(p2));
    check({name, "_conflict"}, {63'd0, arb_conflict}, {63'd0, ec});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    set_req(6'b000000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NF; i++) begin
      fu_rob_index[i] = 6'(i + 8);
      fu_tag[i]       = 6'(i + 40);
      fu_data[i]      = 32'hA0 + 32'(i);
    end

    vecs[0]  = '{6'b010010, 1'b0, 6'b010010,  1,  4, -1, 1'b0};
    vecs[1]  = '{6'b100001, 1'b0, 6'b100001,  5,  0, -1, 1'b0};
    vecs[2]  = '{6'b000000, 1'b0, 6'b000000, -1, -1, -1, 1'b0};
    vecs[3]  = '{6'b001100, 1'b1, 6'b000000, -1, -1, -1, 1'b0};
    vecs[4]  = '{6'b001100, 1'b0, 6'b001100,  2,  3, -1, 1'b0};
    vecs[5]  = '{6'b111111, 1'b0, 6'b110001,  4,  5,  0, 1'b1};
    vecs[6]  = '{6'b111111, 1'b0, 6'b001110,  1,  2,  3, 1'b1};
    vecs[7]  = '{6'b111111, 1'b1, 6'b000000, -1, -1, -1, 1'b0};
    vecs[8]  = '{6'b011111, 1'b0, 6'b010011,  4,  0,  1, 1'b1};
    vecs[9]  = '{6'b000001, 1'b0, 6'b000001,  0, -1, -1, 1'b0};
    vecs[10] = '{6'b100000, 1'b0, 6'b100000,  5, -1, -1, 1'b0};
    vecs[11] = '{6'b111111, 1'b0, 6'b000111,  0,  1,  2, 1'b1};
    vecs[12] = '{6'b111111, 1'b0, 6'b111000,  3,  4,  5, 1'b1};
    vecs[13] = '{6'b001000, 1'b0, 6'b001000,  3, -1, -1, 1'b0};
    vecs[14] = '{6'b101010, 1'b0, 6'b101010,  5,  1,  3, 1'b0};

    do_reset();
    #1;
    check_idle("reset");

    for (int v = 0; v < 15; v++) begin
      step($sformatf("vec%0d", v), vecs[v].req, vecs[v].flush, vecs[v].grant,
           vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].conflict);
    end

    // Asynchronous reset in the middle of a burst, then scan restarts at FU0
    @(negedge clk);
    set_req(6'b111111);
    @(posedge clk);
    #1;
    check("burst_complete0", {63'd0, complete[0]}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    set_req(6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 6'b100001, 1'b0, 6'b100001, 0, 5, -1, 1'b0);
    step("drain", 6'b000000, 1'b0, 6'b000000, -1, -1, -1, 1'b0);

`ifdef COMPLETE_ARB_PERF_EN
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      set_req(6'b111111);
    end
    @(posedge clk);
    #1;
    check("perf_grants", {32'd0, perf_grants}, 64'd30);
    check("perf_conflicts", {32'd0, perf_conflicts}, 64'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
